pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central pipeline controller that drives the stall/flush pair of every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) in the 5-stage core.
- Arbitrates load-use, multi-cycle mul/div occupancy, data-bus wait, branch redirect and trap.
- Sequences mul/div and trap-drain with its own FSM and counter.
- Emits the PC redirect.
- Consumer registers give flush priority over stall.

Parameters:
AW, 64, PC / redirect target width
MDIV_LAT, 4, EX occupancy in cycles of a mul/div op; legal range 2..16
CW, 4, mul/div counter width; must satisfy 2^CW > MDIV_LAT

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
ld_use_i  in  1  ID reports load-use hazard
mdiv_start_i  in  1  EX holds a mul/div op (level; held while stalled)
mem_req_i  in  1  MEM stage has an outstanding data-bus access
mem_ack_i  in  1  data bus completes access this cycle
br_taken_i  in  1  EX resolves taken/mispredicted branch
br_target_i  in  AW  branch target
trap_i  in  1  MEM stage raises exception/interrupt (level; held while stalled)
trap_vec_i  in  AW  trap handler address
stall_o  out  5  per-register stall; bit0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB
flush_o  out  5  per-register flush, same bit order
pc_redirect_o  out  1  PC loads pc_target_o this cycle
pc_target_o  out  AW  redirect address
busy_o  out  1  FSM not in IDLE, or mul/div run flag set

Behaviour:
- Reset (async): FSM to IDLE; md_run=0; cnt=0; trap vector latch=0. During reset all outputs are 0.
- stall_o, flush_o, pc_redirect_o and pc_target_o are combinational from state and inputs (0-cycle latency). Only the FSM, md_run, cnt and the latch are registered.
- FSM states: IDLE, MWAIT, TDRAIN.
- MEMSTALL pattern: stall=01111, flush=10000.
- Priority in IDLE is trap > mem wait > mul/div > branch > load-use. Lower-priority sources are suppressed in that cycle; their stage is held and re-presents them later.
- IDLE, trap_i=1:
  - mem_req_i & !mem_ack_i: latch trap_vec_i, go to TDRAIN, output MEMSTALL.
  - otherwise: flush=11110, redirect to trap_vec_i, stay IDLE. md_run is cleared.
- IDLE, mem_req_i & !mem_ack_i: output MEMSTALL, go to MWAIT. If mem_req_i & mem_ack_i in the same cycle: no stall.
- MWAIT: output MEMSTALL until mem_ack_i. On the ack cycle: no mem stall, return to IDLE.
  - trap_i in MWAIT without ack: latch vector, go to TDRAIN.
  - trap_i on the ack cycle: handle as in IDLE.
- TDRAIN: output MEMSTALL until mem_ack_i. On the ack cycle: flush=11110, redirect to latched vector, go to IDLE.
- Mul/div (evaluated when no mem stall/trap):
  - Start: mdiv_start_i & !md_run sets md_run=1 and cnt=MDIV_LAT-2. Stall=00111, flush=01000 in that cycle.
  - md_run & cnt!=0: same stall/flush pattern; cnt decrements.
  - md_run & cnt==0: release cycle with no mul/div stall; md_run cleared.
  - Net effect: the op occupies EX exactly MDIV_LAT cycles. Back-to-back ops restart cleanly because mdiv_start_i is ignored while md_run=1.
  - cnt decrements every cycle, even under a mem stall. If it reaches 0 during a mem stall, the release waits (md_run held) until the mem stall clears.
- Branch (no higher source active): flush=00110, redirect to br_target_i, no stall.
- Load-use (no higher source active): stall=00011, flush=00100.
- If branch and load-use coincide, the branch wins, because the load-use instruction is squashed.
- pc_target_o = 0 when pc_redirect_o=0.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: adds two 32-bit outputs.
  - perf_stall_cyc_o increments on every cycle with stall_o[0]=1.
  - perf_redirect_cnt_o increments on every pc_redirect_o.
  - Both wrap modulo 2^32 and reset to 0 asynchronously.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/defines:
  - stage index constants (PC=0 … MEM_WB=4);
  - 5-bit stall/flush pattern constants (MEMSTALL, MDIV, LDUSE, BRANCH, TRAP);
  - FSM state encoding.
- Sub-module mdiv_occupancy: md_run plus counter, outputs mdiv_stall. The top holds the FSM and priority mux.

Test Plan:
- rst high mid-MWAIT with stall_o=01111 -> outputs 0 immediately; after release, IDLE with busy_o=0.
- mem_req_i=1 with ack on the 4th cycle -> stall=01111 and flush=10000 for 3 cycles; all 0 on the ack cycle.
- MDIV_LAT=4, mdiv_start_i held -> stall=00111 for 3 cycles, release on the 4th. A second op starting the next cycle gives another 3 stall cycles.
- br_taken_i=1, br_target_i=0x8000_0040 with ld_use_i=1 -> flush=00110, stall=0, pc_redirect_o=1, pc_target_o=0x8000_0040.
- trap_i with trap_vec_i=0x100 raised during an outstanding access, ack 2 cycles later -> MEMSTALL for 2 cycles, then flush=11110 with redirect 0x100 on the ack cycle. trap_vec_i changed meanwhile is ignored.
- Mul/div cnt hits 0 during a mem stall -> EX stays stalled; release occurs on the first non-mem-stall cycle; no extra mul/div cycles are added.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: stage indices,
// stall/flush patterns and FSM state encoding.
package pipe_hazard_ctrl_pkg;

    localparam int STG_PC     = 0;
    localparam int STG_IF_ID  = 1;
    localparam int STG_ID_EX  = 2;
    localparam int STG_EX_MEM = 3;
    localparam int STG_MEM_WB = 4;

    localparam logic [4:0] MEMSTALL_STALL = 5'b01111;
    localparam logic [4:0] MEMSTALL_FLUSH = 5'b10000;
    localparam logic [4:0] MDIV_STALL     = 5'b00111;
    localparam logic [4:0] MDIV_FLUSH     = 5'b01000;
    localparam logic [4:0] LDUSE_STALL    = 5'b00011;
    localparam logic [4:0] LDUSE_FLUSH    = 5'b00100;
    localparam logic [4:0] BRANCH_FLUSH   = 5'b00110;
    localparam logic [4:0] TRAP_FLUSH     = 5'b11110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MWAIT  = 2'd1,
        TDRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_mdiv_occupancy.sv
// Tracks a mul/div op occupying EX for LAT cycles; the counter keeps
// running while blocked, but the release cycle waits for the block to clear.
module mdiv_occupancy #(
    parameter int LAT = 4,
    parameter int CW  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic block,
    input  logic kill,
    output logic stall,
    output logic run
);

    logic [CW-1:0] cnt;

    always_comb begin
        stall = 1'b0;
        if (!block)
            stall = run ? (cnt != '0) : start;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (kill) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (run && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end else if (run && !block) begin
            run <= 1'b0;
        end else if (!run && start && !block) begin
            run <= 1'b1;
            cnt <= CW'(LAT - 2);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush arbiter and PC redirect source.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int AW       = 64,
    parameter int MDIV_LAT = 4,
    parameter int CW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_use_i,
    input  logic          mdiv_start_i,
    input  logic          mem_req_i,
    input  logic          mem_ack_i,
    input  logic          br_taken_i,
    input  logic [AW-1:0] br_target_i,
    input  logic          trap_i,
    input  logic [AW-1:0] trap_vec_i,
    output logic [4:0]    stall_o,
    output logic [4:0]    flush_o,
    output logic          pc_redirect_o,
    output logic [AW-1:0] pc_target_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]   perf_stall_cyc_o,
    output logic [31:0]   perf_redirect_cnt_o,
`endif
    output logic          busy_o
);

    state_t        state, state_n;
    logic [AW-1:0] vec_q;
    logic          ld_vec;
    logic          mem_stall;
    logic          trap_fire;
    logic          md_stall;
    logic          md_run;
    logic [4:0]    stall, flush;
    logic          redir;
    logic [AW-1:0] tgt;

    // Once in MWAIT/TDRAIN the access is outstanding until acked.
    assign mem_stall = (state == IDLE) ? (mem_req_i & ~mem_ack_i) : ~mem_ack_i;
    assign trap_fire = (state == TDRAIN) ? mem_ack_i : (trap_i & ~mem_stall);

    mdiv_occupancy #(
        .LAT (MDIV_LAT),
        .CW  (CW)
    ) u_mdiv (
        .clk   (clk),
        .rst   (rst),
        .start (mdiv_start_i),
        .block (mem_stall | trap_fire),
        .kill  (trap_fire),
        .stall (md_stall),
        .run   (md_run)
    );

    always_comb begin
        state_n = IDLE;
        stall   = '0;
        flush   = '0;
        redir   = 1'b0;
        tgt     = '0;
        ld_vec  = 1'b0;
        if (mem_stall) begin
            stall = MEMSTALL_STALL;
            flush = MEMSTALL_FLUSH;
            if (state == TDRAIN) begin
                state_n = TDRAIN;
            end else if (trap_i) begin
                state_n = TDRAIN;
                ld_vec  = 1'b1;
            end else begin
                state_n = MWAIT;
            end
        end else if (trap_fire) begin
            flush = TRAP_FLUSH;
            redir = 1'b1;
            tgt   = (state == TDRAIN) ? vec_q : trap_vec_i;
        end else if (md_stall) begin
            stall = MDIV_STALL;
            flush = MDIV_FLUSH;
        end else if (br_taken_i) begin
            flush = BRANCH_FLUSH;
            redir = 1'b1;
            tgt   = br_target_i;
        end else if (ld_use_i) begin
            stall = LDUSE_STALL;
            flush = LDUSE_FLUSH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            vec_q <= '0;
        end else begin
            state <= state_n;
            if (ld_vec)
                vec_q <= trap_vec_i;
        end
    end

    assign stall_o       = rst ? '0 : stall;
    assign flush_o       = rst ? '0 : flush;
    assign pc_redirect_o = rst ? 1'b0 : redir;
    assign pc_target_o   = rst ? '0 : tgt;
    assign busy_o        = (state != IDLE) | md_run;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cyc_o    <= '0;
            perf_redirect_cnt_o <= '0;
        end else begin
            if (stall_o[STG_PC])
                perf_stall_cyc_o <= perf_stall_cyc_o + 32'd1;
            if (pc_redirect_o)
                perf_redirect_cnt_o <= perf_redirect_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (default build, MDIV_LAT=4).
module tb_pipe_hazard_ctrl;

    localparam int AW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_use_i, mdiv_start_i, mem_req_i, mem_ack_i;
    logic          br_taken_i, trap_i;
    logic [AW-1:0] br_target_i, trap_vec_i;
    logic [4:0]    stall_o, flush_o;
    logic          pc_redirect_o, busy_o;
    logic [AW-1:0] pc_target_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]   perf_stall_cyc_o, perf_redirect_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.AW(AW), .MDIV_LAT(4), .CW(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .ld_use_i      (ld_use_i),
        .mdiv_start_i  (mdiv_start_i),
        .mem_req_i     (mem_req_i),
        .mem_ack_i     (mem_ack_i),
        .br_taken_i    (br_taken_i),
        .br_target_i   (br_target_i),
        .trap_i        (trap_i),
        .trap_vec_i    (trap_vec_i),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .pc_redirect_o (pc_redirect_o),
        .pc_target_o   (pc_target_o),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cyc_o    (perf_stall_cyc_o),
        .perf_redirect_cnt_o (perf_redirect_cnt_o),
`endif
        .busy_o        (busy_o)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check the full output set mid-cycle, after inputs settle.
    task automatic chk(input string tag, input logic [4:0] s,
                       input logic [4:0] f, input logic r,
                       input logic [63:0] t);
        #1;
        check({tag, ".stall"}, 64'(stall_o), 64'(s));
        check({tag, ".flush"}, 64'(flush_o), 64'(f));
        check({tag, ".redir"}, 64'(pc_redirect_o), 64'(r));
        check({tag, ".tgt"}, pc_target_o, t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ld_use_i = 0; mdiv_start_i = 0; mem_req_i = 0; mem_ack_i = 0;
        br_taken_i = 0; trap_i = 0; br_target_i = '0; trap_vec_i = '0;
    endtask

    initial begin
        idle_in();
        rst = 1;
        #12;
        chk("rst", 5'b0, 5'b0, 0, 0);
        check("rst.busy", 64'(busy_o), 64'd0);
        rst = 0;
        tick();

        // memory wait, ack on 4th cycle
        mem_req_i = 1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mw%0d", i), 5'b01111, 5'b10000, 0, 0);
            tick();
        end
        mem_ack_i = 1;
        chk("mw_ack", 5'b0, 5'b0, 0, 0);
        tick();
        idle_in();
        #1 check("mw_busy", 64'(busy_o), 64'd0);

        // req+ack same cycle: no stall
        mem_req_i = 1; mem_ack_i = 1;
        chk("mack", 5'b0, 5'b0, 0, 0);
        tick();
        idle_in();

        // two back-to-back mul/div ops
        mdiv_start_i = 1;
        for (int op = 0; op < 2; op++) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("md%0d_%0d", op, i), 5'b00111, 5'b01000, 0, 0);
                tick();
            end
            chk($sformatf("md%0d_rel", op), 5'b0, 5'b0, 0, 0);
            #1 check("md_busy", 64'(busy_o), 64'd1);
            tick();
        end
        idle_in();
        #1 check("md_done_busy", 64'(busy_o), 64'd0);

        // branch beats load-use
        br_taken_i = 1; br_target_i = 64'h8000_0040; ld_use_i = 1;
        chk("br", 5'b0, 5'b00110, 1, 64'h8000_0040);
        br_taken_i = 0;
        chk("lduse", 5'b00011, 5'b00100, 0, 0);
        tick();
        idle_in();

        // trap during outstanding access; vector latched
        mem_req_i = 1; trap_i = 1; trap_vec_i = 64'h100;
        chk("td0", 5'b01111, 5'b10000, 0, 0);
        tick();
        trap_vec_i = 64'h200;
        chk("td1", 5'b01111, 5'b10000, 0, 0);
        tick();
        mem_ack_i = 1;
        chk("td_ack", 5'b0, 5'b11110, 1, 64'h100);
        tick();
        idle_in();
        #1 check("td_busy", 64'(busy_o), 64'd0);

        // trap in IDLE, no access
        trap_i = 1; trap_vec_i = 64'h300; ld_use_i = 1;
        chk("trap", 5'b0, 5'b11110, 1, 64'h300);
        tick();
        idle_in();

        // mul/div counter expires under a mem stall
        mdiv_start_i = 1;
        chk("mm_start", 5'b00111, 5'b01000, 0, 0);
        tick();
        mem_req_i = 1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mm_ms%0d", i), 5'b01111, 5'b10000, 0, 0);
            tick();
        end
        mem_ack_i = 1;
        chk("mm_rel", 5'b0, 5'b0, 0, 0);
        tick();
        idle_in();
        chk("mm_after", 5'b0, 5'b0, 0, 0);
        check("mm_busy", 64'(busy_o), 64'd0);

        // reset in the middle of MWAIT
        mem_req_i = 1;
        tick();
        chk("rmw", 5'b01111, 5'b10000, 0, 0);
        rst = 1;
        chk("rmw_rst", 5'b0, 5'b0, 0, 0);
        tick();
        rst = 0;
        mem_req_i = 0;
        chk("rmw_post", 5'b0, 5'b0, 0, 0);
        check("rmw_busy", 64'(busy_o), 64'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
